// File: rtl/master_read.sv
// Single-beat AXI4 read master: turns one CPU load request into one AR/R transaction and stalls the CPU until it completes.
// Optional watchdog enabled by defining MASTER_READ_TIMEOUT_EN.
module master_read #(
   parameter logic [3:0]  MASTER_ID      = 4'd0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   output logic        cpu_stall,
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [3:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_ADDR = 2'b01;
   localparam logic [1:0] S_DATA = 2'b10;
   localparam logic [1:0] S_DONE = 2'b11;

   // Watchdog limit below 1 would make the terminal-count compare underflow
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("master_read: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]  state_q;
   logic [1:0]  state_d;
   logic [31:0] addr_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        arvalid_q;
   logic        rready_q;

   logic        addr_load;
   logic        beat_take;
   logic        tmo;
   logic        tmo_hit;
   logic        busy;

   assign busy = (state_q == S_ADDR) || (state_q == S_DATA);

`ifdef MASTER_READ_TIMEOUT_EN
   localparam int unsigned WDOG_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WDOG_W-1:0] wdog_q;

   // Counter steps every busy cycle; hitting the limit on this edge ends the access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_q <= '0;
      end else if (addr_load) begin
         wdog_q <= '0;
      end else if (busy) begin
         wdog_q <= wdog_q + WDOG_W'(1);
      end
   end

   assign tmo_hit = busy && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      state_d   = state_q;
      addr_load = 1'b0;
      beat_take = 1'b0;
      tmo       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_load = 1'b1;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (ARREADY) begin
               state_d = S_DATA;
            end else if (tmo_hit) begin
               tmo     = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DATA: begin
            if (RVALID && (RID == MASTER_ID)) begin
               beat_take = 1'b1;
               if (RLAST) begin
                  state_d = S_DONE;
               end
            end
            // A genuine last beat takes priority over an expiring watchdog
            if ((state_d != S_DONE) && tmo_hit) begin
               tmo     = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, handshake and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         arvalid_q <= (state_d == S_ADDR);
         rready_q  <= (state_d == S_DATA);
         if (addr_load) begin
            addr_q <= cpu_addr;
         end
         if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end else if (beat_take) begin
            rdata_q <= RDATA;
            err_q   <= (RRESP != 2'b00);
         end
      end
   end

   // Stall follows the request in IDLE so the CPU never sees a false release
   assign cpu_stall = rst && (busy || ((state_q == S_IDLE) && cpu_req));

   assign cpu_rdata = rdata_q;
   assign cpu_err   = err_q;
   assign ARID      = MASTER_ID;
   assign ARADDR    = addr_q;
   assign ARLEN     = 4'd0;
   assign ARSIZE    = 3'b010;
   assign ARBURST   = 2'b01;
   assign ARVALID   = arvalid_q;
   assign RREADY    = rready_q;

endmodule

// File: tb/tb_master_read.sv
// Directed bench for master_read with a result scoreboard; timeout case runs when MASTER_READ_TIMEOUT_EN is defined.
module tb_master_read;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        cpu_stall;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY = 1'b0;
   logic [3:0]  RID = '0;
   logic [31:0] RDATA = '0;
   logic [1:0]  RRESP = '0;
   logic        RLAST = 1'b0;
   logic        RVALID = 1'b0;
   logic        RREADY;

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   master_read #(.MASTER_ID(4'd0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at the negedge where DONE is expected
   task automatic check_done();
      exp_t e;
      chk("done_stall_low", 32'(cpu_stall), 32'd0);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("cpu_rdata", cpu_rdata, e.data);
         chk("cpu_err", 32'(cpu_err), 32'(e.err));
      end else begin
         chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end
   endtask

   // Full read starting at a negedge in IDLE; ends at a negedge in IDLE with req low
   task automatic read_txn(input logic [31:0] addr, input int ar_wait,
                           input logic drop_first, input logic [31:0] data,
                           input logic [1:0] resp);
      int   cyc;
      exp_t e;
      cpu_req  = 1'b1;
      cpu_addr = addr;
      #1;
      chk("idle_stall_req", 32'(cpu_stall), 32'd1);
      @(negedge clk);
      cyc      = 1;
      cpu_addr = 32'hFFFF_FFFF;
      for (int i = 0; i < ar_wait; i++) begin
         chk("ar_valid_hold", 32'(ARVALID), 32'd1);
         chk("ar_addr_hold", ARADDR, addr);
         chk("rready_in_addr", 32'(RREADY), 32'd0);
         RVALID = 1'b1;
         RID    = 4'd0;
         RLAST  = 1'b1;
         RDATA  = 32'hBAD0_0000 | 32'(i);
         @(negedge clk);
         cyc++;
      end
      RVALID  = 1'b0;
      RLAST   = 1'b0;
      chk("ar_valid", 32'(ARVALID), 32'd1);
      chk("ar_addr", ARADDR, addr);
      ARREADY = 1'b1;
      @(negedge clk);
      cyc++;
      ARREADY = 1'b0;
      chk("ar_valid_drop", 32'(ARVALID), 32'd0);
      chk("rready_data", 32'(RREADY), 32'd1);
      if (drop_first) begin
         RVALID = 1'b1;
         RID    = 4'hF;
         RDATA  = ~data;
         RRESP  = 2'b11;
         RLAST  = 1'b1;
         @(negedge clk);
         cyc++;
         chk("stall_after_foreign_beat", 32'(cpu_stall), 32'd1);
      end
      RVALID = 1'b1;
      RID    = 4'd0;
      RDATA  = data;
      RRESP  = resp;
      RLAST  = 1'b1;
      e.data = data;
      e.err  = (resp != 2'b00);
      exp_q.push_back(e);
      do begin
         @(negedge clk);
         cyc++;
         RVALID = 1'b0;
         RLAST  = 1'b0;
      end while (cpu_stall && cyc < 40);
      chk("done_latency", 32'(cyc), 32'(3 + ar_wait + (drop_first ? 1 : 0)));
      check_done();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("idle_arvalid", 32'(ARVALID), 32'd0);
      chk("idle_rready", 32'(RREADY), 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_arvalid", 32'(ARVALID), 32'd0);
      chk("rst_rready", 32'(RREADY), 32'd0);
      chk("rst_araddr", ARADDR, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_err", 32'(cpu_err), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("arlen", 32'(ARLEN), 32'd0);
      chk("arsize", 32'(ARSIZE), 32'd2);
      chk("arburst", 32'(ARBURST), 32'd1);
      chk("arid", 32'(ARID), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      read_txn(32'h0001_0010, 1, 1'b0, 32'hDEAD_BEEF, 2'b00);
      read_txn(32'h0000_0040, 0, 1'b0, 32'hCAFE_F00D, 2'b11);
      read_txn(32'h0000_1234, 5, 1'b0, 32'h0BAD_F00D, 2'b00);
      read_txn(32'h0002_0000, 0, 1'b1, 32'h1234_5678, 2'b00);
      read_txn(32'h0003_0004, 2, 1'b1, 32'h5555_AAAA, 2'b10);

      // Reset while waiting for data
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_0100;
      @(negedge clk);
      ARREADY = 1'b1;
      @(negedge clk);
      ARREADY = 1'b0;
      chk("pre_rst_rready", 32'(RREADY), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_arvalid", 32'(ARVALID), 32'd0);
      chk("mid_rst_rready", 32'(RREADY), 32'd0);
      chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
      @(negedge clk);
      rst     = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      read_txn(32'h0000_0200, 0, 1'b0, 32'h8765_4321, 2'b00);

`ifdef MASTER_READ_TIMEOUT_EN
      begin
         int   cyc;
         exp_t e;
         cpu_req  = 1'b1;
         cpu_addr = 32'h0000_0300;
         @(negedge clk);
         cyc     = 1;
         ARREADY = 1'b1;
         @(negedge clk);
         cyc++;
         ARREADY = 1'b0;
         e.data  = 32'h0;
         e.err   = 1'b1;
         exp_q.push_back(e);
         do begin
            @(negedge clk);
            cyc++;
         end while (cpu_stall && cyc < 40);
         chk("timeout_latency", 32'(cyc), 32'd17);
         check_done();
         cpu_req = 1'b0;
         @(negedge clk);
         chk("timeout_idle_rready", 32'(RREADY), 32'd0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "simulation did not finish");
   end

endmodule
